// File: rtl/ldpc_3gpp_enc_buffer_if.sv
// Handshake and data bus between the encoder source stage, the bank buffer and its reader.
// The master side is the source/reader pair that drives strobes and addresses into the buffer.
interface ldpc_3gpp_enc_buffer_if #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8
);
    logic               iclkena;
    logic               iwrite;
    logic               iwfull;
    logic [pADDR_W-1:0] iwaddr;
    logic [pDAT_W-1:0]  iwdat;
    logic               irempty;
    logic [pADDR_W-1:0] iraddr;
    logic               ofulla;
    logic               oemptya;
    logic               orfull;
    logic [pDAT_W-1:0]  ordat;
    logic               oerr;

    modport master (
        output iclkena, iwrite, iwfull, iwaddr, iwdat, irempty, iraddr,
        input  ofulla, oemptya, orfull, ordat, oerr
    );

    modport slave (
        input  iclkena, iwrite, iwfull, iwaddr, iwdat, irempty, iraddr,
        output ofulla, oemptya, orfull, ordat, oerr
    );
endinterface

// File: rtl/ldpc_3gpp_enc_buffer.sv
// Multi-bank frame buffer between the LDPC source stage and the encoder.
// Each write frame fills one bank; the reader consumes banks in the order they were closed.
module ldpc_3gpp_enc_buffer #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8,
    parameter int pBNUM_W = 1
) (
    input logic                      iclk,
    input logic                      ireset,
    ldpc_3gpp_enc_buffer_if.slave    bus
);
    localparam int NB    = 1 << pBNUM_W;
    localparam int DEPTH = NB << pADDR_W;
    localparam logic [pBNUM_W:0] cNB = (pBNUM_W + 1)'(NB);

    logic [pDAT_W-1:0]  mem [DEPTH];
    logic [pBNUM_W-1:0] wbank;
    logic [pBNUM_W-1:0] rbank;
    logic [pBNUM_W:0]   cnt;
    logic               err;
    logic [pDAT_W-1:0]  rdat;

    logic full;
    logic empty;
    logic wr_ok;
    logic push;
    logic pop;
    logic wr_ovf;
    logic rd_unf;

    assign full   = (cnt == cNB);
    assign empty  = (cnt == '0);
    assign wr_ok  = bus.iwrite & ~full;
    assign push   = wr_ok & bus.iwfull;
    assign pop    = bus.irempty & ~empty;
    assign wr_ovf = bus.iwrite & full;
    assign rd_unf = bus.irempty & empty;

    // Storage is never cleared; only accepted writes outside reset touch it.
    always_ff @(posedge iclk) begin
        if (ireset && bus.iclkena && wr_ok)
            mem[{wbank, bus.iwaddr}] <= bus.iwdat;
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            wbank <= '0;
            rbank <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            rdat  <= '0;
        end else if (bus.iclkena) begin
            rdat <= mem[{rbank, bus.iraddr}];
            if (push)
                wbank <= wbank + pBNUM_W'(1);
            if (pop)
                rbank <= rbank + pBNUM_W'(1);
            if (push && !pop)
                cnt <= cnt + (pBNUM_W + 1)'(1);
            else if (pop && !push)
                cnt <= cnt - (pBNUM_W + 1)'(1);
            if (wr_ovf || rd_unf)
                err <= 1'b1;
        end
    end

    // Flags are forced to their idle values while reset is held, before the first reset edge lands.
    assign bus.ofulla  = ireset & full;
    assign bus.oemptya = ~ireset | empty;
    assign bus.orfull  = ireset & ~empty;
    assign bus.ordat   = rdat;
    assign bus.oerr    = err;
endmodule
